jtdd_adpcm_chan: RTL and testbench

JTDD_ADPCM_CHAN -- requirements
Module: jtdd_adpcm_chan

---
 rtl/jtdd_adpcm_chan_if.sv | 29 ++
 rtl/jtdd_adpcm_chan.sv | 211 +++++++++++++++++++++
 tb/tb_jtdd_adpcm_chan.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtdd_adpcm_chan_if.sv
// Bus bundle for one ADPCM channel.
//
// Carries the CPU register-write port and the ADPCM ROM port.
//   CPU side : cpu_cen (bus clock enable), cpu_dout[7:0] (write data),
//              cpu_AB[1:0] (register select), cs (qualified write strobe)
//   ROM side : rom_addr[15:0] (byte address), rom_cs (request / busy),
//              rom_data[7:0] (read data), rom_ok (rom_data valid for rom_addr)
// master : CPU + ROM model side (drives writes and ROM responses)
// slave  : the channel (drives rom_addr / rom_cs)
interface jtdd_adpcm_chan_if;
  logic        cpu_cen;
  logic [7:0]  cpu_dout;
  logic [1:0]  cpu_AB;
  logic        cs;
  logic [15:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;

  modport master (
    output cpu_cen, cpu_dout, cpu_AB, cs, rom_data, rom_ok,
    input  rom_addr, rom_cs
  );

  modport slave (
    input  cpu_cen, cpu_dout, cpu_AB, cs, rom_data, rom_ok,
    output rom_addr, rom_cs
  );
endinterface

// File: rtl/jtdd_adpcm_chan.sv
// Single OKI MSM5205-style ADPCM playback channel.
//
// The CPU sets start/end addresses (512-byte granularity) and starts/stops
// playback. Every 48th cen_oki pulse a sample strobe fires; while playing, one
// nibble is fetched from ROM (high nibble first) and decoded into a 12-bit
// saturating accumulator, which appears on snd one clk later.
//
// Ports:
//   clk      : system clock
//   rstn     : asynchronous active-low reset
//   cen_oki  : 375 kHz clock enable, one clk wide
//   bus      : CPU write port and ROM port (jtdd_adpcm_chan_if.slave)
//   snd      : signed 12-bit decoded sample
//   sample   : one-clk pulse per output sample period
//
// Build option:
//   JTDD_ADPCM_HOLD_EN : when defined, snd keeps its last value after playback
//                        ends; otherwise snd returns to 0 one clk after playing
//                        falls.
module jtdd_adpcm_chan (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cen_oki,
  jtdd_adpcm_chan_if.slave    bus,
  output logic signed [11:0]  snd,
  output logic                sample
);

  localparam logic [5:0] PreLast = 6'd47;  // 48 cen_oki pulses per sample
  localparam logic [5:0] IdxMax  = 6'd48;

  logic               playing;
  logic [6:0]         start_hi;
  logic [6:0]         end_hi;
  logic [15:0]        ptr;
  logic               phase;      // 0: high nibble, 1: low nibble
  logic [5:0]         presc;
  logic signed [11:0] acc;
  logic [5:0]         idx;

  logic wr;
  logic start_wr;
  logic stop_wr;
  logic strobe;
  logic at_end;
  logic unused_dout7;

  assign wr       = bus.cs & bus.cpu_cen;
  assign start_wr = wr && (bus.cpu_AB == 2'd0);
  assign stop_wr  = wr && (bus.cpu_AB == 2'd1);
  assign strobe   = cen_oki && (presc == PreLast);
  assign at_end   = (ptr == {end_hi, 9'h000});

  assign bus.rom_addr = ptr;
  assign bus.rom_cs   = playing;

  // Address registers only hold bits 15:9.
  assign unused_dout7 = bus.cpu_dout[7];

  // Decoder datapath
  logic [3:0]         nib;
  logic [3:0]         mag;
  logic [10:0]        step;
  logic [14:0]        prod;
  logic signed [13:0] acc_ext;
  logic signed [13:0] diff_ext;
  logic signed [13:0] sum;
  logic signed [11:0] acc_next;
  logic signed [7:0]  idx_delta;
  logic signed [7:0]  idx_sum;
  logic [5:0]         idx_next;

  always_comb begin
    unique case (idx)
      6'd0:  step = 11'd16;
      6'd1:  step = 11'd17;
      6'd2:  step = 11'd19;
      6'd3:  step = 11'd21;
      6'd4:  step = 11'd23;
      6'd5:  step = 11'd25;
      6'd6:  step = 11'd28;
      6'd7:  step = 11'd31;
      6'd8:  step = 11'd34;
      6'd9:  step = 11'd37;
      6'd10: step = 11'd41;
      6'd11: step = 11'd45;
      6'd12: step = 11'd50;
      6'd13: step = 11'd55;
      6'd14: step = 11'd60;
      6'd15: step = 11'd66;
      6'd16: step = 11'd73;
      6'd17: step = 11'd80;
      6'd18: step = 11'd88;
      6'd19: step = 11'd97;
      6'd20: step = 11'd107;
      6'd21: step = 11'd118;
      6'd22: step = 11'd130;
      6'd23: step = 11'd143;
      6'd24: step = 11'd157;
      6'd25: step = 11'd173;
      6'd26: step = 11'd190;
      6'd27: step = 11'd209;
      6'd28: step = 11'd230;
      6'd29: step = 11'd253;
      6'd30: step = 11'd279;
      6'd31: step = 11'd307;
      6'd32: step = 11'd337;
      6'd33: step = 11'd371;
      6'd34: step = 11'd408;
      6'd35: step = 11'd449;
      6'd36: step = 11'd494;
      6'd37: step = 11'd544;
      6'd38: step = 11'd598;
      6'd39: step = 11'd658;
      6'd40: step = 11'd724;
      6'd41: step = 11'd796;
      6'd42: step = 11'd876;
      6'd43: step = 11'd963;
      6'd44: step = 11'd1060;
      6'd45: step = 11'd1166;
      6'd46: step = 11'd1282;
      6'd47: step = 11'd1411;
      default: step = 11'd1552;  // idx is clamped to 48
    endcase
  end

  always_comb begin
    nib = phase ? bus.rom_data[3:0] : bus.rom_data[7:4];
    // step*(2m+1)/8 with m = nib[2:0]
    mag      = {nib[2:0], 1'b1};
    prod     = 15'(step) * 15'(mag);
    diff_ext = 14'(prod >> 3);
    acc_ext  = {{2{acc[11]}}, acc};
    sum      = nib[3] ? (acc_ext - diff_ext) : (acc_ext + diff_ext);
    if (sum > 14'sd2047) begin
      acc_next = 12'sd2047;
    end else if (sum < -14'sd2048) begin
      acc_next = -12'sd2048;
    end else begin
      acc_next = sum[11:0];
    end

    unique case (nib[2:0])
      3'd4:    idx_delta = 8'sd2;
      3'd5:    idx_delta = 8'sd4;
      3'd6:    idx_delta = 8'sd6;
      3'd7:    idx_delta = 8'sd8;
      default: idx_delta = -8'sd1;
    endcase
    idx_sum = $signed({2'b00, idx}) + idx_delta;
    if (idx_sum < 8'sd0) begin
      idx_next = 6'd0;
    end else if (idx_sum > 8'sd48) begin
      idx_next = IdxMax;
    end else begin
      idx_next = idx_sum[5:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      playing  <= 1'b0;
      start_hi <= '0;
      end_hi   <= '0;
      ptr      <= '0;
      phase    <= 1'b0;
      presc    <= '0;
      acc      <= '0;
      idx      <= '0;
      snd      <= '0;
      sample   <= 1'b0;
    end else begin
      sample <= strobe;

      if (cen_oki) begin
        presc <= (presc == PreLast) ? 6'd0 : presc + 6'd1;
      end

      if (wr && (bus.cpu_AB == 2'd2)) start_hi <= bus.cpu_dout[6:0];
      if (wr && (bus.cpu_AB == 2'd3)) end_hi   <= bus.cpu_dout[6:0];

      // Stop has priority over start; CPU commands take precedence over a
      // coincident strobe.
      if (stop_wr) begin
        playing <= 1'b0;
      end else if (start_wr) begin
        playing <= 1'b1;
        ptr     <= {start_hi, 9'h000};
        phase   <= 1'b0;
        acc     <= '0;
        idx     <= '0;
      end else if (strobe && playing) begin
        if (at_end) begin
          playing <= 1'b0;
        end else if (bus.rom_ok) begin
          acc   <= acc_next;
          idx   <= idx_next;
          phase <= ~phase;
          if (phase) ptr <= ptr + 16'd1;
        end
      end

`ifdef JTDD_ADPCM_HOLD_EN
      if (playing) snd <= acc;
`else
      snd <= playing ? acc : 12'sd0;
`endif
    end
  end

endmodule

// File: tb/tb_jtdd_adpcm_chan.sv
// Self-checking bench for jtdd_adpcm_chan: directed scenarios plus a random
// phase, all compared against a behavioural model of the channel.
module tb_jtdd_adpcm_chan;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cen_oki = 1'b0;
  logic signed [11:0] snd;
  logic sample;

  jtdd_adpcm_chan_if bus ();

  jtdd_adpcm_chan dut (
    .clk     (clk),
    .rstn    (rstn),
    .cen_oki (cen_oki),
    .bus     (bus),
    .snd     (snd),
    .sample  (sample)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int oki_div = 2;
  bit oki_rand = 1'b0;

  // Reference model state
  int step_tab[49];
  int m_play, m_ptr, m_phase, m_acc, m_idx, m_snd, m_sample, m_pulses, m_start, m_end;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               tag, $signed(got), got, $signed(exp), exp, cyc);
      if (bad >= 40) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  task automatic model_edge();
    int n_snd, n_start, n_end, nib, m, diff;
    bit strobe, wr;
    if (!rstn) begin
      m_play = 0; m_ptr = 0; m_phase = 0; m_acc = 0; m_idx = 0;
      m_snd = 0; m_sample = 0; m_pulses = 0; m_start = 0; m_end = 0;
      return;
    end
`ifdef JTDD_ADPCM_HOLD_EN
    n_snd = m_play ? m_acc : m_snd;
`else
    n_snd = m_play ? m_acc : 0;
`endif
    strobe = 1'b0;
    if (cen_oki) begin
      m_pulses++;
      strobe = (m_pulses % 48 == 0);
    end
    wr = bus.cs && bus.cpu_cen;
    n_start = m_start;
    n_end = m_end;
    if (wr && bus.cpu_AB == 2'd2) n_start = int'(bus.cpu_dout[6:0]) * 512;
    if (wr && bus.cpu_AB == 2'd3) n_end = int'(bus.cpu_dout[6:0]) * 512;
    if (wr && bus.cpu_AB == 2'd1) begin
      m_play = 0;
    end else if (wr && bus.cpu_AB == 2'd0) begin
      m_play = 1; m_ptr = m_start; m_phase = 0; m_acc = 0; m_idx = 0;
    end else if (strobe && m_play != 0) begin
      if (m_ptr == m_end) begin
        m_play = 0;
      end else if (bus.rom_ok) begin
        nib = m_phase != 0 ? int'(bus.rom_data[3:0]) : int'(bus.rom_data[7:4]);
        m = nib % 8;
        diff = step_tab[m_idx] * (2 * m + 1) / 8;
        m_acc = (nib >= 8) ? m_acc - diff : m_acc + diff;
        if (m_acc > 2047) m_acc = 2047;
        if (m_acc < -2048) m_acc = -2048;
        m_idx = m_idx + ((m < 4) ? -1 : 2 * (m - 3));
        if (m_idx < 0) m_idx = 0;
        if (m_idx > 48) m_idx = 48;
        if (m_phase != 0) begin
          m_ptr = (m_ptr + 1) % 65536;
          m_phase = 0;
        end else begin
          m_phase = 1;
        end
      end
    end
    m_start = n_start;
    m_end = n_end;
    m_snd = n_snd;
    m_sample = strobe;
  endtask

  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = {2'b00, 1'(m_sample), 1'(m_play), 16'(m_ptr), 12'(m_snd)};
    check("cycle", {2'b00, sample, bus.rom_cs, bus.rom_addr, snd}, e);
    cyc++;
    if (oki_rand) cen_oki = 1'($urandom_range(0, 1));
    else cen_oki = (cyc % oki_div == 0);
  endtask

  task automatic cpu_wr(input logic [1:0] ab, input logic [7:0] d);
    bus.cs = 1'b1; bus.cpu_cen = 1'b1; bus.cpu_AB = ab; bus.cpu_dout = d;
    tick();
    bus.cs = 1'b0; bus.cpu_cen = 1'b0;
  endtask

  task automatic wait_sample();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!sample && n < 400);
    if (!sample) check("sample_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    real r;
    int c0, n, nibs, maxs, s_before;
    logic [15:0] a_before;

    r = 16.0;
    for (int i = 0; i < 49; i++) begin
      step_tab[i] = int'($floor(r));
      r = r * 1.1;
    end

    bus.cs = 1'b0; bus.cpu_cen = 1'b0; bus.cpu_AB = 2'd0; bus.cpu_dout = 8'h00;
    bus.rom_data = 8'h00; bus.rom_ok = 1'b1;

    // Reset held
    for (int i = 0; i < 5; i++) tick();
    check("rst_cs", bus.rom_cs, 0);
    check("rst_addr", bus.rom_addr, 0);
    check("rst_snd", snd, 0);
    check("rst_sample", sample, 0);

    // Idle after reset: sample every 48 cen_oki pulses
    rstn = 1'b1;
    oki_div = 2;
    wait_sample();
    c0 = cyc;
    wait_sample();
    check("sample_period", cyc - c0, 96);
    check("idle_snd", snd, 0);
    check("idle_cs", bus.rom_cs, 0);

    // Full playback 0x0200..0x0400 with 0x77
    cpu_wr(2'd2, 8'h01);
    cpu_wr(2'd3, 8'h02);
    bus.rom_data = 8'h77;
    bus.rom_ok = 1'b1;
    oki_div = 1;
    cpu_wr(2'd0, 8'h00);
    check("start_addr", bus.rom_addr, 16'h0200);
    check("start_cs", bus.rom_cs, 1);
    wait_sample();
    tick();
    check("first_snd", int'(snd), 30);
    nibs = 1;
    maxs = int'(snd);
    n = 0;
    while (bus.rom_cs && n < 60000) begin
      tick();
      n++;
      if (sample && bus.rom_cs) nibs++;
      if (int'(snd) > maxs) maxs = int'(snd);
    end
    check("nibbles", nibs, 1024);
    check("end_addr", bus.rom_addr, 16'h0400);
    check("end_cs", bus.rom_cs, 0);
    check("sat_max", maxs, 2047);
    tick();
`ifdef JTDD_ADPCM_HOLD_EN
    check("end_snd", int'(snd), 2047);
`else
    check("end_snd", int'(snd), 0);
`endif

    // Alternating +2 / -2 with 0x08
    bus.rom_data = 8'h08;
    oki_div = 2;
    cpu_wr(2'd0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_sample();
      tick();
      check("alt_snd", int'(snd), (k % 2 == 0) ? 2 : 0);
    end

    // rom_ok low across a strobe: nothing moves
    bus.rom_ok = 1'b0;
    a_before = bus.rom_addr;
    s_before = int'(snd);
    wait_sample();
    tick();
    check("nok_snd", int'(snd), s_before);
    check("nok_addr", bus.rom_addr, a_before);
    bus.rom_ok = 1'b1;
    wait_sample();
    tick();
    check("resume_snd", int'(snd), (s_before == 2) ? 0 : 2);

    // Stop mid-play
    s_before = int'(snd);
    cpu_wr(2'd1, 8'h00);
    check("stop_cs", bus.rom_cs, 0);
    tick();
`ifdef JTDD_ADPCM_HOLD_EN
    check("stop_snd", int'(snd), s_before);
`else
    check("stop_snd", int'(snd), 0);
`endif

    // Random phase, with one mid-run reset
    oki_rand = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      bus.rom_data = 8'($urandom);
      bus.rom_ok = ($urandom_range(0, 7) != 0);
      bus.cpu_cen = 1'($urandom_range(0, 1));
      bus.cs = ($urandom_range(0, 99) == 0);
      bus.cpu_AB = 2'($urandom_range(0, 3));
      bus.cpu_dout = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      if (i == 7000) begin
        rstn = 1'b0;
        #1;
        check("async_rst_cs", bus.rom_cs, 0);
        check("async_rst_addr", bus.rom_addr, 0);
      end
      if (i == 7003) rstn = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
